// File: rtl/alu_operand_stage.sv
// Pipeline register stage in front of the ALU: 2-entry skid buffer with a registered inReady.
// Define ALU_OPERAND_STAGE_FWD_EN to patch waiting operands from the writeback port.
module alu_operand_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned OP_W   = 4,
    parameter int unsigned TAG_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inValid,
    output logic              inReady,
    input  logic [OP_W-1:0]   inAluOp,
    input  logic [DATA_W-1:0] inLeft,
    input  logic [DATA_W-1:0] inRight,
    input  logic [TAG_W-1:0]  inLeftTag,
    input  logic [TAG_W-1:0]  inRightTag,
    input  logic [TAG_W-1:0]  inDestTag,
    output logic              outValid,
    input  logic              outReady,
    output logic [OP_W-1:0]   outAluOp,
    output logic [DATA_W-1:0] outLeft,
    output logic [DATA_W-1:0] outRight,
    output logic [TAG_W-1:0]  outDestTag,
    input  logic              wbValid,
    input  logic [TAG_W-1:0]  wbTag,
    input  logic [DATA_W-1:0] wbData
);

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] left;
        logic [DATA_W-1:0] right;
        logic [TAG_W-1:0]  ltag;
        logic [TAG_W-1:0]  rtag;
        logic [TAG_W-1:0]  dest;
    } entry_t;

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    state_e state_q, state_d;
    entry_t head_q, head_d;
    entry_t skid_q, skid_d;
    logic   in_ready_q;

    entry_t in_entry;
    entry_t in_fwd, head_fwd, skid_fwd;
    logic   in_xfer, out_xfer;

    assign in_entry = '{op: inAluOp, left: inLeft, right: inRight,
                        ltag: inLeftTag, rtag: inRightTag, dest: inDestTag};

`ifdef ALU_OPERAND_STAGE_FWD_EN
    // Tag 0 is x0 and never forwarded; left and right match independently.
    function automatic entry_t patch(entry_t e, logic v, logic [TAG_W-1:0] t,
                                     logic [DATA_W-1:0] d);
        entry_t r;
        r = e;
        if (v && (t != '0)) begin
            if (e.ltag == t) r.left = d;
            if (e.rtag == t) r.right = d;
        end
        return r;
    endfunction

    assign in_fwd   = patch(in_entry, wbValid, wbTag, wbData);
    assign head_fwd = patch(head_q, wbValid, wbTag, wbData);
    assign skid_fwd = patch(skid_q, wbValid, wbTag, wbData);
`else
    logic unused_fwd;

    assign in_fwd     = in_entry;
    assign head_fwd   = head_q;
    assign skid_fwd   = skid_q;
    assign unused_fwd = ^{wbValid, wbTag, wbData, head_q.ltag, head_q.rtag,
                          skid_q.ltag, skid_q.rtag};
`endif

    assign outValid = (state_q != StEmpty);
    assign inReady  = in_ready_q;
    assign in_xfer  = inValid & in_ready_q;
    assign out_xfer = outValid & outReady;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StEmpty;
            head_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != StTwo);
        end
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_fwd;
        skid_d  = skid_fwd;
        unique case (state_q)
            StEmpty: begin
                if (in_xfer) begin
                    state_d = StOne;
                    head_d  = in_fwd;
                end
            end
            StOne: begin
                if (in_xfer && out_xfer) begin
                    head_d = in_fwd;
                end else if (in_xfer) begin
                    state_d = StTwo;
                    skid_d  = in_fwd;
                end else if (out_xfer) begin
                    state_d = StEmpty;
                end
            end
            StTwo: begin
                if (out_xfer) begin
                    state_d = StOne;
                    head_d  = skid_fwd;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_comb begin
        outAluOp   = head_q.op;
        outLeft    = head_q.left;
        outRight   = head_q.right;
        outDestTag = head_q.dest;
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed table, throughput, random vs queue model.
// Honours ALU_OPERAND_STAGE_FWD_EN in its expectations.
module tb_alu_operand_stage;

    logic        clk;
    logic        rst_n;
    logic        inValid;
    logic        inReady;
    logic [3:0]  inAluOp;
    logic [31:0] inLeft;
    logic [31:0] inRight;
    logic [4:0]  inLeftTag;
    logic [4:0]  inRightTag;
    logic [4:0]  inDestTag;
    logic        outValid;
    logic        outReady;
    logic [3:0]  outAluOp;
    logic [31:0] outLeft;
    logic [31:0] outRight;
    logic [4:0]  outDestTag;
    logic        wbValid;
    logic [4:0]  wbTag;
    logic [31:0] wbData;

    alu_operand_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .inValid   (inValid),
        .inReady   (inReady),
        .inAluOp   (inAluOp),
        .inLeft    (inLeft),
        .inRight   (inRight),
        .inLeftTag (inLeftTag),
        .inRightTag(inRightTag),
        .inDestTag (inDestTag),
        .outValid  (outValid),
        .outReady  (outReady),
        .outAluOp  (outAluOp),
        .outLeft   (outLeft),
        .outRight  (outRight),
        .outDestTag(outDestTag),
        .wbValid   (wbValid),
        .wbTag     (wbTag),
        .wbData    (wbData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] l;
        logic [31:0] r;
        logic [4:0]  lt;
        logic [4:0]  rt;
        logic [4:0]  d;
    } ent_t;

    typedef struct {
        logic        iv;
        logic        ordy;
        logic [3:0]  op;
        logic [31:0] l;
        logic [31:0] r;
        logic [4:0]  lt;
        logic [4:0]  rt;
        logic [4:0]  d;
        logic        wv;
        logic [4:0]  wt;
        logic [31:0] wd;
        logic        ev;
        logic        er;
        logic [31:0] el;
        logic [4:0]  ed;
    } vec_t;

    ent_t q[$];
    logic rdy_exp = 1'b0;
    logic fresh = 1'b1;
    int   nvec = 0;
    int   nerr = 0;
    vec_t tbl[14];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endfunction

    function automatic vec_t mk(logic iv, logic ordy, logic [3:0] op, logic [31:0] l,
                                logic [31:0] r, logic [4:0] lt, logic [4:0] rt,
                                logic [4:0] d, logic wv, logic [4:0] wt, logic [31:0] wd,
                                logic ev, logic er, logic [31:0] el, logic [4:0] ed);
        vec_t v;
        v = '{iv, ordy, op, l, r, lt, rt, d, wv, wt, wd, ev, er, el, ed};
        return v;
    endfunction

    // One clock edge: the model consumes the inputs seen at the edge, then outputs are checked.
    task automatic cycle();
        logic        iv, ordy, rst, wv, in_x, out_x;
        logic [4:0]  wt;
        logic [31:0] wd;
        ent_t        e;
        iv   = inValid;
        ordy = outReady;
        rst  = rst_n;
        wv   = wbValid;
        wt   = wbTag;
        wd   = wbData;
        e    = '{inAluOp, inLeft, inRight, inLeftTag, inRightTag, inDestTag};
        @(posedge clk);
        #1;
        if (!rst) begin
            q.delete();
            rdy_exp = 1'b0;
            fresh   = 1'b1;
        end else begin
            in_x  = iv && rdy_exp;
            out_x = (q.size() > 0) && ordy;
`ifdef ALU_OPERAND_STAGE_FWD_EN
            if (wv && wt != 5'd0) begin
                foreach (q[i]) begin
                    if (q[i].lt == wt) q[i].l = wd;
                    if (q[i].rt == wt) q[i].r = wd;
                end
                if (e.lt == wt) e.l = wd;
                if (e.rt == wt) e.r = wd;
            end
`else
            if (wv && wt == 5'd31 && wd == 32'd0) fresh = fresh;
`endif
            if (out_x) void'(q.pop_front());
            if (in_x) begin
                q.push_back(e);
                fresh = 1'b0;
            end
            rdy_exp = (q.size() < 2);
        end
        chk("outValid", outValid, q.size() > 0);
        chk("inReady", inReady, rdy_exp);
        if (q.size() > 0) begin
            chk("outAluOp", outAluOp, q[0].op);
            chk("outLeft", outLeft, q[0].l);
            chk("outRight", outRight, q[0].r);
            chk("outDestTag", outDestTag, q[0].d);
        end else if (fresh) begin
            chk("rst_data", {outAluOp, outDestTag} ^ outLeft ^ outRight, 32'd0);
            chk("rst_left", outLeft, 32'd0);
        end
    endtask

    task automatic idle_inputs();
        inValid = 1'b0; outReady = 1'b0; inAluOp = '0; inLeft = '0; inRight = '0;
        inLeftTag = '0; inRightTag = '0; inDestTag = '0;
        wbValid = 1'b0; wbTag = '0; wbData = '0;
    endtask

    initial begin
        logic [31:0] fwd_l;
`ifdef ALU_OPERAND_STAGE_FWD_EN
        fwd_l = 32'hDEADBEEF;
`else
        fwd_l = 32'h0000_1111;
`endif
        //          iv ordy op    L         R         lt rt d  wv wt wd            ev er el      ed
        tbl[0]  = mk(1, 1, 4'h2, 32'd5,  32'd7,  0, 0, 3, 0, 0, 0,            1, 1, 32'd5,  3);
        tbl[1]  = mk(0, 1, 4'h0, 32'd0,  32'd0,  0, 0, 0, 0, 0, 0,            0, 1, 32'd0,  0);
        tbl[2]  = mk(1, 0, 4'h1, 32'd10, 32'd20, 0, 0, 1, 0, 0, 0,            1, 1, 32'd10, 1);
        tbl[3]  = mk(1, 0, 4'h5, 32'd11, 32'd21, 0, 0, 2, 0, 0, 0,            1, 0, 32'd10, 1);
        tbl[4]  = mk(1, 0, 4'h9, 32'd12, 32'd22, 0, 0, 3, 0, 0, 0,            1, 0, 32'd10, 1);
        tbl[5]  = mk(1, 0, 4'h9, 32'd12, 32'd22, 0, 0, 3, 0, 0, 0,            1, 0, 32'd10, 1);
        tbl[6]  = mk(1, 1, 4'h9, 32'd12, 32'd22, 0, 0, 3, 0, 0, 0,            1, 1, 32'd11, 2);
        tbl[7]  = mk(1, 0, 4'h9, 32'd12, 32'd22, 0, 0, 3, 0, 0, 0,            1, 0, 32'd11, 2);
        tbl[8]  = mk(0, 1, 4'h0, 32'd0,  32'd0,  0, 0, 0, 0, 0, 0,            1, 1, 32'd12, 3);
        tbl[9]  = mk(0, 1, 4'h0, 32'd0,  32'd0,  0, 0, 0, 0, 0, 0,            0, 1, 32'd0,  0);
        tbl[10] = mk(1, 0, 4'h3, 32'h1111, 32'h2222, 4, 9, 7, 0, 0, 0,        1, 1, 32'h1111, 7);
        tbl[11] = mk(0, 0, 4'h0, 32'd0,  32'd0,  0, 0, 0, 1, 4, 32'hDEADBEEF, 1, 1, fwd_l,  7);
        tbl[12] = mk(0, 0, 4'h0, 32'd0,  32'd0,  0, 0, 0, 1, 0, 32'hCAFEF00D, 1, 1, fwd_l,  7);
        tbl[13] = mk(0, 1, 4'h0, 32'd0,  32'd0,  0, 0, 0, 0, 0, 0,            0, 1, 32'd0,  0);

        // Reset held 3 cycles with decode offering work.
        idle_inputs();
        rst_n   = 1'b0;
        inValid = 1'b1;
        inLeft  = 32'h55;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("rst_outValid", outValid, 1'b0);
            chk("rst_inReady", inReady, 1'b0);
        end
        rst_n   = 1'b1;
        inValid = 1'b0;
        cycle();
        chk("post_rst_inReady", inReady, 1'b1);

        // Directed table: latency, backpressure ordering, forwarding.
        for (int i = 0; i < 14; i++) begin
            inValid = tbl[i].iv; outReady = tbl[i].ordy; inAluOp = tbl[i].op;
            inLeft = tbl[i].l; inRight = tbl[i].r; inLeftTag = tbl[i].lt;
            inRightTag = tbl[i].rt; inDestTag = tbl[i].d;
            wbValid = tbl[i].wv; wbTag = tbl[i].wt; wbData = tbl[i].wd;
            cycle();
            chk($sformatf("tbl%0d_valid", i), outValid, tbl[i].ev);
            chk($sformatf("tbl%0d_ready", i), inReady, tbl[i].er);
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_left", i), outLeft, tbl[i].el);
                chk($sformatf("tbl%0d_dest", i), outDestTag, tbl[i].ed);
            end
        end
        idle_inputs();

        // Full throughput: one beat per cycle, inReady never drops.
        outReady = 1'b1;
        for (int i = 0; i < 16; i++) begin
            inValid   = 1'b1;
            inLeft    = i;
            inRight   = 32'd100 + i;
            inDestTag = 5'(i);
            cycle();
            chk("thru_left", outLeft, i);
            chk("thru_ready", inReady, 1'b1);
        end
        inValid = 1'b0;
        cycle();

        // Random traffic with small tag space so forwarding hits often.
        for (int i = 0; i < 400; i++) begin
            inValid    = 1'($urandom_range(0, 1));
            outReady   = 1'($urandom_range(0, 1));
            inAluOp    = 4'($urandom);
            inLeft     = $urandom;
            inRight    = $urandom;
            inLeftTag  = 5'($urandom_range(0, 3));
            inRightTag = 5'($urandom_range(0, 3));
            inDestTag  = 5'($urandom);
            wbValid    = 1'($urandom_range(0, 1));
            wbTag      = 5'($urandom_range(0, 3));
            wbData     = $urandom;
            cycle();
        end
        idle_inputs();

        // Drain, fill to two entries, then reset mid-operation.
        outReady = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        outReady = 1'b0;
        inValid  = 1'b1;
        inLeft   = 32'hA5A5;
        cycle();
        inLeft = 32'h5A5A;
        cycle();
        chk("two_inReady", inReady, 1'b0);
        chk("two_outValid", outValid, 1'b1);
        rst_n   = 1'b0;
        inValid = 1'b0;
        cycle();
        chk("rst_two_outValid", outValid, 1'b0);
        rst_n = 1'b1;
        cycle();
        chk("rst_two_inReady", inReady, 1'b1);
        chk("rst_two_empty", outValid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
